seq_mult_bcd: RTL and testbench

- Parametrised sequential shift-add multiplier with signed/unsigned mode and a start/busy/done handshake.
- Converts the product magnitude to packed BCD using a multi-cycle double-dabble engine, one bit per clock.
- Serves as the arithmetic/display back end feeding the 7-segment and UART-print blocks.
- Replaces fixed-width, single-cycle-conversion multipliers; width and digit count are set by parameters.

---
 rtl/seq_mult_bcd.sv | 140 ++++++++++++++
 tb/tb_seq_mult_bcd.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_bcd.sv
// Sequential shift-add multiplier (signed/unsigned) followed by a
// bit-serial double-dabble conversion of the product magnitude to packed BCD.
module seq_mult_bcd #(
    parameter int N      = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [N-1:0]          a_in,
    input  logic [N-1:0]          b_in,
    output logic                  busy,
    output logic                  done,
    output logic [2*N-1:0]        product,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_neg,
    output logic                  bcd_ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(2 * N + 1);

    localparam logic [CW-1:0] C_N  = CW'(N);
    localparam logic [CW-1:0] C_2N = CW'(2 * N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_BCD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mult;
    logic [2*N-1:0] r_shreg;
    logic [BW-1:0]  r_work;
    logic [2*N-1:0] r_product;
    logic [BW-1:0]  r_bcd;
    logic           r_bcd_neg;
    logic           r_bcd_ovf;

    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic [2*N-1:0] w_acc_nxt;
    logic           w_res_neg;
    logic [BW-1:0]  w_adj;
    logic [BW-1:0]  w_work_nxt;

    // |-2^(N-1)| wraps to itself, which is the correct unsigned magnitude
    assign w_mag_a = (signed_mode && a_in[N-1]) ? -a_in : a_in;
    assign w_mag_b = (signed_mode && b_in[N-1]) ? -b_in : b_in;

    assign w_acc_nxt = r_mult[0] ? (r_acc + r_mcand) : r_acc;
    assign w_res_neg = r_neg && (w_acc_nxt != '0);

    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_work_nxt = {w_adj[BW-2:0], r_shreg[2*N-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mult    <= '0;
            r_shreg   <= '0;
            r_work    <= '0;
            r_product <= '0;
            r_bcd     <= '0;
            r_bcd_neg <= 1'b0;
            r_bcd_ovf <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_neg     <= signed_mode & (a_in[N-1] ^ b_in[N-1]);
                        r_mcand   <= {{N{1'b0}}, w_mag_a};
                        r_mult    <= w_mag_b;
                        r_acc     <= '0;
                        r_cnt     <= C_N;
                        r_bcd_ovf <= 1'b0;
                        r_state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc   <= w_acc_nxt;
                    r_mcand <= r_mcand << 1;
                    r_mult  <= r_mult >> 1;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_shreg   <= w_acc_nxt;
                        r_work    <= '0;
                        r_product <= w_res_neg ? -w_acc_nxt : w_acc_nxt;
                        r_bcd_neg <= w_res_neg;
                        r_cnt     <= C_2N;
                        r_state   <= S_BCD;
                    end
                end
                S_BCD: begin
                    r_work  <= w_work_nxt;
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt - 1'b1;
                    if (w_adj[BW-1]) begin
                        r_bcd_ovf <= 1'b1;
                    end
                    if (r_cnt == CW'(1)) begin
                        r_bcd   <= w_work_nxt;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == S_MUL) || (r_state == S_BCD);
    assign done    = (r_state == S_DONE);
    assign product = r_product;
    assign bcd     = r_bcd;
    assign bcd_neg = r_bcd_neg;
    assign bcd_ovf = r_bcd_ovf;

endmodule

// File: tb/tb_seq_mult_bcd.sv
// Directed bench for seq_mult_bcd: a DIGITS=5 instance for the main
// function and a DIGITS=4 instance for the overflow/truncation path.
module tb_seq_mult_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0;
    logic        start1;
    logic        signed_mode;
    logic [7:0]  a_in;
    logic [7:0]  b_in;

    logic        busy0, done0, neg0, ovf0;
    logic [15:0] prod0;
    logic [19:0] bcd0;
    logic        busy1, done1, neg1, ovf1;
    logic [15:0] prod1;
    logic [15:0] bcd1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_mult_bcd #(.N(8), .DIGITS(5)) u_dut5 (
        .clk(clk), .reset(reset), .start(start0),
        .signed_mode(signed_mode), .a_in(a_in), .b_in(b_in),
        .busy(busy0), .done(done0), .product(prod0), .bcd(bcd0),
        .bcd_neg(neg0), .bcd_ovf(ovf0)
    );

    seq_mult_bcd #(.N(8), .DIGITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start1),
        .signed_mode(signed_mode), .a_in(a_in), .b_in(b_in),
        .busy(busy1), .done(done1), .product(prod1), .bcd(bcd1),
        .bcd_neg(neg1), .bcd_ovf(ovf1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch one op; leaves the bench at the negedge just after the start edge
    task automatic launch(input bit which, input logic sm,
                          input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        signed_mode = sm;
        a_in = a;
        b_in = b;
        if (which) start1 = 1'b1;
        else       start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        signed_mode = ~sm;
        a_in = 8'h5A;
        b_in = 8'hA5;
    endtask

    task automatic wait_done(input bit which, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!(which ? done1 : done0) && lat < 100) begin
            if (which ? busy1 : busy0) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic sm,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] e_prod, input logic [19:0] e_bcd,
                          input logic e_neg);
        int lat, bcnt;
        launch(1'b0, sm, a, b);
        wait_done(1'b0, lat, bcnt);
        check_eq({tag, "_lat"}, lat, 24);
        check_eq({tag, "_prod"}, prod0, e_prod);
        check_eq({tag, "_bcd"}, bcd0, e_bcd);
        check_eq({tag, "_neg"}, neg0, e_neg);
        check_eq({tag, "_ovf"}, ovf0, 1'b0);
        @(negedge clk);
        check_eq({tag, "_done_end"}, done0, 1'b0);
    endtask

    initial begin
        int lat, bcnt, d1, d2, cyc, ndone;

        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        signed_mode = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_done", done0, 1'b0);
        check_eq("rst_prod", prod0, 16'h0);
        check_eq("rst_bcd", bcd0, 20'h0);
        check_eq("rst_flags", {neg0, ovf0}, 2'b00);
        reset = 1'b0;

        launch(1'b0, 1'b0, 8'd255, 8'd255);
        wait_done(1'b0, lat, bcnt);
        check_eq("u255_lat", lat, 24);
        check_eq("u255_busy", bcnt, 24);
        check_eq("u255_prod", prod0, 16'hFE01);
        check_eq("u255_bcd", bcd0, 20'h65025);
        check_eq("u255_flags", {neg0, ovf0}, 2'b00);
        @(negedge clk);
        check_eq("u255_pulse", done0, 1'b0);

        run_op("s128", 1'b1, 8'h80, 8'h80, 16'h4000, 20'h16384, 1'b0);
        run_op("sm3x7", 1'b1, 8'hFD, 8'h07, 16'hFFEB, 20'h00021, 1'b1);
        run_op("sm5x0", 1'b1, 8'hFB, 8'h00, 16'h0000, 20'h00000, 1'b0);
        run_op("u0x0", 1'b0, 8'h00, 8'h00, 16'h0000, 20'h00000, 1'b0);

        // Extra start in the middle of busy must be ignored
        launch(1'b0, 1'b0, 8'd3, 8'd4);
        repeat (4) @(negedge clk);
        a_in = 8'd9;
        b_in = 8'd9;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(1'b0, lat, bcnt);
        check_eq("ign_lat", lat + 5, 24);
        check_eq("ign_prod", prod0, 16'd12);
        check_eq("ign_bcd", bcd0, 20'h00012);
        @(negedge clk);
        @(negedge clk);
        check_eq("ign_idle", busy0, 1'b0);

        // Held start: done pulses spaced by 3N+2
        signed_mode = 1'b0;
        a_in = 8'd2;
        b_in = 8'd3;
        start0 = 1'b1;
        d1 = -1;
        d2 = -1;
        cyc = 0;
        while (d2 < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done0) begin
                if (d1 < 0) d1 = cyc;
                else        d2 = cyc;
            end
        end
        check_eq("held_period", d2 - d1, 26);
        check_eq("held_prod", prod0, 16'd6);
        start0 = 1'b0;
        cyc = 0;
        while ((busy0 || done0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("held_stop", busy0, 1'b0);

        // Reset during cycle 10 of busy aborts without done
        launch(1'b0, 1'b0, 8'd255, 8'd255);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", busy0, 1'b0);
        check_eq("abort_done", done0, 1'b0);
        check_eq("abort_prod", prod0, 16'h0);
        check_eq("abort_bcd", bcd0, 20'h0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check_eq("abort_nodone", ndone, 0);
        run_op("u12", 1'b0, 8'd12, 8'd12, 16'd144, 20'h00144, 1'b0);

        // Four-digit instance: truncation and sticky-flag clear
        launch(1'b1, 1'b0, 8'd255, 8'd255);
        wait_done(1'b1, lat, bcnt);
        check_eq("d4_lat", lat, 24);
        check_eq("d4_ovf", ovf1, 1'b1);
        check_eq("d4_bcd", bcd1, 16'h5025);
        check_eq("d4_prod", prod1, 16'hFE01);
        @(negedge clk);
        launch(1'b1, 1'b0, 8'd99, 8'd99);
        wait_done(1'b1, lat, bcnt);
        check_eq("d4b_ovf", ovf1, 1'b0);
        check_eq("d4b_bcd", bcd1, 16'h9801);
        check_eq("d4b_prod", prod1, 16'h2649);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
